// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_pkg : shared constants and helpers for the FIFO blocks
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;

    // Bounded loop so the function stays elaborable by synthesis tools.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO, registered read port, sticky overflow flag.
// Optional occupancy output enabled by macro SYNC_FIFO_COUNT_EN.
// Revision  : 1.0 - initial release
// ---------------------------------------------------------------------------
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
`ifdef SYNC_FIFO_COUNT_EN
    output logic [clog2(DEPTH):0] count,
`endif
    output logic                  overflow
);

    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  overflow_q, overflow_d;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign w_wr_acc = wr_en && !full;
    assign w_rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        overflow_d = overflow_q | (wr_en & full);
        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (w_rd_acc) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left unreset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign overflow = overflow_q;

`ifdef SYNC_FIFO_COUNT_EN
    assign count = wr_ptr_q - rd_ptr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sync_fifo : directed + random checks of sync_fifo (DEPTH=4) against a
// queue-based reference model.  Revision 1.0
// ---------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 4;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          overflow;
`ifdef SYNC_FIFO_COUNT_EN
    logic [2:0]    count;
`endif

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
`ifdef SYNC_FIFO_COUNT_EN
        .count    (count),
`endif
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total;
    int            bad;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_rd;
    logic          exp_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":empty"},    32'(empty),    32'(mq.size() == 0));
        chk({tag, ":full"},     32'(full),     32'(mq.size() == DP));
        chk({tag, ":overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, ":rd_data"},  32'(rd_data),  32'(exp_rd));
`ifdef SYNC_FIFO_COUNT_EN
        chk({tag, ":count"},    32'(count),    32'(mq.size()));
`endif
    endtask

    // Drive one cycle of requests, update the model from pre-edge occupancy,
    // then check outputs on the following falling edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input string tag);
        int occ;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        occ     = mq.size();
        @(posedge clk);
        if (w && occ == DP) exp_ovf = 1'b1;
        if (r && occ > 0)   exp_rd  = mq.pop_front();
        if (w && occ < DP)  mq.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        mq.delete();
        exp_rd  = '0;
        exp_ovf = 1'b0;
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_rd  = '0;
        exp_ovf = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        rst_n   = 1'b1;
        @(negedge clk);
        do_reset("reset");
        step(1'b0, 8'h00, 1'b0, "idle");

        // Fill, overflow attempt, drain.
        step(1'b1, 8'h11, 1'b0, "fill1");
        step(1'b1, 8'h22, 1'b0, "fill2");
        step(1'b1, 8'h33, 1'b0, "fill3");
        step(1'b1, 8'h44, 1'b0, "fill4");
        step(1'b1, 8'h55, 1'b0, "ovf_wr");
        step(1'b1, 8'h66, 1'b1, "ovf_wr_rd");
        step(1'b0, 8'h00, 1'b1, "drain1");
        step(1'b0, 8'h00, 1'b1, "drain2");
        step(1'b0, 8'h00, 1'b1, "drain3");
        step(1'b0, 8'h00, 1'b1, "drain_empty_rd");
        do_reset("ovf_clear");

        // Two stored, then simultaneous read/write across wrap.
        step(1'b1, 8'h01, 1'b0, "pre1");
        step(1'b1, 8'h02, 1'b0, "pre2");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h03 + i), 1'b1, "simul");
        end
        step(1'b0, 8'h00, 1'b1, "post1");
        step(1'b0, 8'h00, 1'b1, "post2");
        step(1'b0, 8'h00, 1'b1, "empty_rd");
        step(1'b1, 8'hA5, 1'b1, "empty_wr_rd");
        step(1'b0, 8'h00, 1'b1, "rd_a5");

        // Occupancy sequence 1,2,3,2 then reset mid-sequence.
        step(1'b1, 8'hC1, 1'b0, "cnt1");
        step(1'b1, 8'hC2, 1'b0, "cnt2");
        step(1'b1, 8'hC3, 1'b0, "cnt3");
        step(1'b0, 8'h00, 1'b1, "cnt2b");
        do_reset("mid_reset");
        step(1'b0, 8'h00, 1'b1, "post_reset_rd");

        for (int i = 0; i < 400; i++) begin
            step(1'(($urandom % 100) < 55), 8'($urandom), 1'(($urandom % 100) < 45), "rand");
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 1'b1, "final_drain");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, synchronous first-in-first-out buffer with a registered read port and a sticky overflow flag. The spike router uses it to queue incoming spike events ({timestamp, neuron_id}) until its routing state machine dequeues them. The block is generic in data width and depth.

Parameters:
DATA_WIDTH, 8, width of each stored word in bits (≥1).
DEPTH, 16, number of storage entries; must be a power of two and ≥2.
ADDR_W (localparam), clog2(DEPTH), storage index width; pointers are ADDR_W+1 bits.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
wr_en  input  1  write request.
wr_data  input  DATA_WIDTH  word to enqueue.
full  output  1  high when DEPTH entries are stored.
rd_en  input  1  read request.
rd_data  output  DATA_WIDTH  registered head word, valid the cycle after an accepted read.
empty  output  1  high when 0 entries are stored.
overflow  output  1  sticky; set by a write request while full.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): wr_ptr=0, rd_ptr=0, rd_data=0, overflow=0. Outputs: full=0, empty=1. Storage contents are not cleared.
- Pointers: ADDR_W+1 bits. The low ADDR_W bits index storage. The MSB is the wrap bit. Pointers increment modulo 2^(ADDR_W+1).
- empty = (wr_ptr == rd_ptr). full = (MSBs differ) && (low bits equal). Both are combinational from the registered pointers.
- Accepted write: wr_en && !full, evaluated with the pre-edge full. mem[wr_ptr low bits] <= wr_data; wr_ptr increments.
- Accepted read: rd_en && !empty, evaluated with the pre-edge empty. rd_data <= mem[rd_ptr low bits]; rd_ptr increments. Read latency is 1 cycle: data is on rd_data the cycle after rd_en.
- rd_data holds its previous value when no read is accepted.
- Write while full: the write is dropped and the contents are unchanged. overflow <= 1 and stays set until reset. This applies even if rd_en is asserted in the same cycle: only the read is accepted and the occupancy drops to DEPTH-1.
- Read while empty: ignored. Pointers and rd_data are unchanged. No error flag is raised.
- Read and write in the same cycle when 0 < occupancy < DEPTH: both are accepted and the occupancy is unchanged.
- Read and write in the same cycle when empty: only the write is accepted. There is no fall-through, so empty deasserts on the next cycle.
- Ordering is strict FIFO across pointer wrap-around. There are no bubbles.
- Reset asserted mid-operation discards all queued words; the block restarts empty.

Optional Feature:
Macro SYNC_FIFO_COUNT_EN.
- Defined: adds output port count [ADDR_W:0], equal to wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)). It gives the occupancy 0..DEPTH, reads 0 after reset and is updated with the pointers.
- Not defined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- A shared package fifo_pkg holds the clog2 constant function and a default-depth constant.
- Pointer/flag logic and storage stay in this one module. No sub-module is needed; the memory is an inferred array (block or distributed RAM by depth).

Test Plan:
- Reset, then idle → empty=1, full=0, overflow=0, rd_data=0.
- DATA_WIDTH=8, DEPTH=4: write 0x11,0x22,0x33,0x44 on consecutive cycles → full=1 after the 4th edge; then read 4 times → rd_data=0x11,0x22,0x33,0x44, each one cycle after its rd_en; empty=1 after the last read.
- Full FIFO (DEPTH=4), wr_en with 0x55 → 0x55 is not stored and overflow=1; overflow stays 1 after the FIFO drains, and a subsequent rst_n pulse clears it.
- With 2 entries stored, assert wr_en=1 and rd_en=1 together for 10 cycles using an incrementing pattern → occupancy stays 2, outputs are in order, pointers wrap correctly.
- Empty FIFO, rd_en alone → rd_data unchanged, empty stays 1. Empty FIFO, wr_en+rd_en together → only the write is stored, empty=0 next cycle.
- SYNC_FIFO_COUNT_EN defined: 3 writes, 1 read → count sequence 1,2,3,2. Assert rst_n low mid-sequence → count=0 and empty=1 immediately.
